// File: rtl/wshb_frame_reader.sv
// Wishbone classic read master that fetches one video frame from the SDRAM
// framebuffer into a small first-word-fall-through FIFO for the video path.
// One transfer is outstanding at a time. A request is issued only while the
// FIFO has room, so the FIFO cannot overflow.
module wshb_frame_reader #(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        frame_start,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [31:0] wb_adr,
    output logic [3:0]  wb_sel,
    output logic [2:0]  wb_cti,
    output logic [1:0]  wb_bte,
    input  logic [31:0] wb_dat_sm,
    input  logic        wb_ack,
    input  logic        wb_err,
    input  logic        wb_rty,
    input  logic        rd_en,
    output logic [23:0] rd_data,
    output logic        empty,
    output logic        frame_done,
    output logic        underflow
);

    localparam int unsigned NPIX = HDISP * VDISP;
    localparam int unsigned IDXW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = PTRW + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPIX - 1);
    localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_SPACE
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    // One-cycle request holdoff after err/rty and after an abort.
    logic            gap_q, gap_d;

    logic [PTRW-1:0] wptr_q, rptr_q;
    logic [CNTW-1:0] cnt_q;
    logic            underflow_q;
    logic [23:0]     mem_q [FIFO_DEPTH];

    logic            room;
    logic            push;
    logic            pop;
    logic            flush;

    // Bits 31:24 of the pixel word carry nothing the video path needs.
    logic            unused_dat;
    assign unused_dat = ^wb_dat_sm[31:24];

    // Read-only classic cycles, full word lanes.
    assign wb_we  = 1'b0;
    assign wb_sel = 4'hF;
    assign wb_cti = 3'b000;
    assign wb_bte = 2'b00;
    assign wb_adr = BASE_ADDR + (32'(idx_q) << 2);

    // The space check uses the registered count. A word acked this cycle is
    // already reflected in the count by the time the next request could be issued.
    assign room = (cnt_q < DEPTH_C);

    // State, pixel index and holdoff registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state logic, bus strobes, FIFO push/flush and the end-of-frame pulse.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = 1'b0;
        wb_cyc     = 1'b0;
        wb_stb     = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                end
            end
            S_FETCH: begin
                wb_cyc = !gap_q && room;
                wb_stb = !gap_q && room;
                if (frame_start) begin
                    // Abort: drop the bus, ignore any ack this cycle, restart clean.
                    flush = 1'b1;
                    idx_d = '0;
                    gap_d = 1'b1;
                end else if (wb_stb && wb_ack) begin
                    push = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        frame_done = 1'b1;
                        idx_d      = '0;
                        state_d    = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end else if (wb_stb && (wb_err || wb_rty)) begin
                    gap_d = 1'b1;
                end else if (!room) begin
                    state_d = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (frame_start) begin
                    flush   = 1'b1;
                    idx_d   = '0;
                    gap_d   = 1'b1;
                    state_d = S_FETCH;
                end else if (room) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pop is blocked by a flush in the same cycle.
    assign pop     = rd_en && !empty && !flush;
    assign empty   = (cnt_q == '0);
    assign rd_data = empty ? 24'h0 : mem_q[rptr_q];
    assign underflow = underflow_q;

    // FIFO pointers, fill count and sticky underflow flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + PTRW'(1);
                if (pop)  rptr_q <= rptr_q + PTRW'(1);
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + CNTW'(1);
                    2'b01:   cnt_q <= cnt_q - CNTW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
            if (frame_start)
                underflow_q <= 1'b0;
            else if (rd_en && empty)
                underflow_q <= 1'b1;
        end
    end

    // FIFO storage; contents are don't-care until written, rd_data is masked when empty.
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wptr_q] <= wb_dat_sm[23:0];
    end

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Directed bench for wshb_frame_reader: 4x2 frame at 0x100 through a 4-deep FIFO,
// with a one-cycle-latency Wishbone slave that can inject a single err.
module tb_wshb_frame_reader;

    localparam int unsigned HDISP      = 4;
    localparam int unsigned VDISP      = 2;
    localparam logic [31:0] BASE       = 32'h0000_0100;
    localparam int unsigned FIFO_DEPTH = 4;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        frame_start;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic [31:0] wb_dat_sm;
    logic        wb_ack, wb_err, wb_rty;
    logic        rd_en;
    logic [23:0] rd_data;
    logic        empty, frame_done, underflow;

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    int done_cnt = 0;
    int done_at_ack = -1;
    int err_cnt = 0;
    logic [31:0] adr_log [$];
    logic [23:0] pop_log [$];
    logic [31:0] err_adr;

    wshb_frame_reader #(
        .HDISP(HDISP), .VDISP(VDISP), .BASE_ADDR(BASE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte),
        .wb_dat_sm(wb_dat_sm), .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
        .frame_done(frame_done), .underflow(underflow)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Slave returns a word derived from the address so order can be checked.
    assign wb_dat_sm = {8'hEE, 8'h5A, wb_adr[15:0]};
    assign wb_rty    = 1'b0;

    function automatic logic [23:0] px(input logic [31:0] a);
        return {8'h5A, a[15:0]};
    endfunction

    // Slave: terminate one cycle after a fresh strobe; err once on err_adr.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
        end else begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            if (wb_cyc && wb_stb && !wb_ack && !wb_err) begin
                if (wb_adr == err_adr && err_cnt == 0) begin
                    wb_err  <= 1'b1;
                    err_cnt <= err_cnt + 1;
                end else begin
                    wb_ack <= 1'b1;
                end
            end
        end
    end

    // Monitor: accepted transfers, frame_done pulses and popped pixels.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (wb_cyc && wb_stb && wb_ack && !frame_start) begin
                ack_cnt <= ack_cnt + 1;
                adr_log.push_back(wb_adr);
            end
            if (frame_done) begin
                done_cnt    <= done_cnt + 1;
                done_at_ack <= ack_cnt + 1;
            end
            if (rd_en && !empty && !frame_start) pop_log.push_back(rd_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int a0, d0, l0, p0, n;
        sys_rst_n   = 1'b0;
        frame_start = 1'b0;
        rd_en       = 1'b0;
        err_adr     = 32'hFFFF_FFFF;
        #12;
        chk("rst_cyc", 32'(wb_cyc), 0);
        chk("rst_stb", 32'(wb_stb), 0);
        chk("rst_adr", wb_adr, BASE);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_uf", 32'(underflow), 0);
        chk("rst_rdata", 32'(rd_data), 0);
        chk("rst_we", 32'(wb_we), 0);
        chk("rst_sel", 32'(wb_sel), 32'hF);
        chk("rst_cti_bte", 32'({wb_cti, wb_bte}), 0);
        @(posedge sys_clk); #1 sys_rst_n = 1'b1;

        // Full frame with the reader always popping.
        a0 = ack_cnt; d0 = done_cnt; l0 = adr_log.size(); p0 = pop_log.size();
        @(posedge sys_clk); #1 rd_en = 1'b1; frame_start = 1'b1;
        @(posedge sys_clk); #1 frame_start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 100) begin @(negedge sys_clk); n++; end
        chk("frame_timeout", 32'(n < 100), 1);
        repeat (4) @(negedge sys_clk);
        chk("f_acks", ack_cnt - a0, 8);
        chk("f_done_once", done_cnt - d0, 1);
        chk("f_done_on_8th", done_at_ack - a0, 8);
        for (int i = 0; i < 8; i++) chk("f_adr", adr_log[l0 + i], BASE + 32'(4 * i));
        chk("f_npop", pop_log.size() - p0, 8);
        for (int i = 0; i < 8; i++) chk("f_pix", 32'(pop_log[p0 + i]), 32'(px(BASE + 32'(4 * i))));
        chk("f_idle_cyc", 32'(wb_cyc), 0);

        // Underflow is sticky after rd_en on empty; frame_start in IDLE clears it.
        @(posedge sys_clk); #1 rd_en = 1'b0;
        @(negedge sys_clk);
        chk("uf_set", 32'(underflow), 1);
        chk("uf_empty", 32'(empty), 1);
        a0 = ack_cnt; l0 = adr_log.size();
        @(posedge sys_clk); #1 frame_start = 1'b1;
        @(posedge sys_clk); #1 frame_start = 1'b0;
        @(negedge sys_clk);
        chk("uf_clr", 32'(underflow), 0);

        // Backpressure: no reads, so fetch stops at FIFO_DEPTH words.
        repeat (30) @(negedge sys_clk);
        chk("bp_acks", ack_cnt - a0, 4);
        chk("bp_cyc_low", 32'(wb_cyc), 0);
        chk("bp_head", 32'(rd_data), 32'(px(BASE)));
        chk("bp_adr3", adr_log[l0 + 3], BASE + 32'd12);
        @(posedge sys_clk); #1 rd_en = 1'b1;
        @(posedge sys_clk); #1 rd_en = 1'b0;
        repeat (20) @(negedge sys_clk);
        chk("bp_one_more", ack_cnt - a0, 5);
        chk("bp_adr4", adr_log[l0 + 4], BASE + 32'd16);
        chk("bp_cyc_low2", 32'(wb_cyc), 0);
        chk("bp_head2", 32'(rd_data), 32'(px(BASE + 32'd4)));

        // Abort after 5 of 8 acks: flush, gap, restart from BASE.
        a0 = ack_cnt; d0 = done_cnt; p0 = pop_log.size();
        @(posedge sys_clk); #1 frame_start = 1'b1;
        @(posedge sys_clk); #1 frame_start = 1'b0;
        @(negedge sys_clk);
        chk("ab_empty", 32'(empty), 1);
        chk("ab_gap", 32'(wb_cyc), 0);
        @(negedge sys_clk);
        chk("ab_stb", 32'(wb_stb), 1);
        chk("ab_adr", wb_adr, BASE);
        @(posedge sys_clk); #1 rd_en = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 100) begin @(negedge sys_clk); n++; end
        chk("ab_timeout", 32'(n < 100), 1);
        repeat (4) @(negedge sys_clk);
        chk("ab_acks", ack_cnt - a0, 8);
        chk("ab_done_once", done_cnt - d0, 1);
        chk("ab_pix0", 32'(pop_log[p0]), 32'(px(BASE)));
        chk("ab_pix7", 32'(pop_log[p0 + 7]), 32'(px(BASE + 32'd28)));

        // err on idx 3: nothing pushed, one-cycle strobe gap, same address retried.
        @(posedge sys_clk); #1 rd_en = 1'b0; err_adr = BASE + 32'd12;
        a0 = ack_cnt;
        @(posedge sys_clk); #1 frame_start = 1'b1;
        @(posedge sys_clk); #1 frame_start = 1'b0;
        n = 0;
        while (!wb_err && n < 30) begin @(negedge sys_clk); n++; end
        chk("er_timeout", 32'(n < 30), 1);
        chk("er_adr", wb_adr, BASE + 32'd12);
        chk("er_acks3", ack_cnt - a0, 3);
        @(negedge sys_clk);
        chk("er_gap", 32'(wb_stb), 0);
        @(negedge sys_clk);
        chk("er_retry_stb", 32'(wb_stb), 1);
        chk("er_retry_adr", wb_adr, BASE + 32'd12);
        repeat (10) @(negedge sys_clk);
        chk("er_acks4", ack_cnt - a0, 4);
        chk("er_cyc_low", 32'(wb_cyc), 0);
        @(posedge sys_clk); #1 rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            chk("er_fifo", 32'(rd_data), 32'(px(BASE + 32'(4 * i))));
            @(posedge sys_clk); #1;
        end
        rd_en = 1'b0;

        // Async reset in the middle of a fetch with underflow set.
        @(posedge sys_clk); #1 rd_en = 1'b1; frame_start = 1'b1;
        @(posedge sys_clk); #1 frame_start = 1'b0;
        n = 0;
        while (!(wb_cyc && underflow) && n < 40) begin @(negedge sys_clk); n++; end
        chk("rs_midfetch", 32'(n < 40), 1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rs_cyc", 32'(wb_cyc), 0);
        chk("rs_stb", 32'(wb_stb), 0);
        chk("rs_empty", 32'(empty), 1);
        chk("rs_uf", 32'(underflow), 0);
        chk("rs_adr", wb_adr, BASE);
        chk("rs_rdata", 32'(rd_data), 0);
        @(posedge sys_clk); #1 sys_rst_n = 1'b1; rd_en = 1'b0;
        repeat (2) @(posedge sys_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
